// File: rtl/alu_sub.sv
// Pipelined subtract slice: rd = rs1 - rs2 with zero/neg/borrow/ovf flags, one cycle latency.
// Optional build macro ALU_SUB_SAT_EN saturates rd on signed overflow instead of wrapping.
module alu_sub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic [WIDTH-1:0] rd,
  output logic             out_valid,
  output logic             zero,
  output logic             neg,
  output logic             borrow,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_next;
  logic [WIDTH-1:0] diff_next;
  logic [WIDTH-1:0] result_next;
  logic             borrow_next;
  logic             ovf_next;
  logic             zero_next;
  logic             neg_next;

  // Carry-out of rs1 + ~rs2 + 1 is the inverse of the unsigned borrow.
  assign sum_next    = {1'b0, rs1} + {1'b0, ~rs2} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_next   = sum_next[WIDTH-1:0];
  assign borrow_next = ~sum_next[WIDTH];
  assign ovf_next    = (rs1[MSB] ^ rs2[MSB]) & (diff_next[MSB] ^ rs1[MSB]);

`ifdef ALU_SUB_SAT_EN
  logic [WIDTH-1:0] sat_next;

  // Overflow direction follows the sign of the minuend.
  assign sat_next    = rs1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign result_next = ovf_next ? sat_next : diff_next;
`else
  assign result_next = diff_next;
`endif

  assign zero_next = ~|result_next;
  assign neg_next  = result_next[MSB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        rd     <= result_next;
        zero   <= zero_next;
        neg    <= neg_next;
        borrow <= borrow_next;
        ovf    <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_sub.sv
// Scoreboard bench for alu_sub: stimulus pushes model results, a negedge monitor pops and compares.
module tb_alu_sub;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] rd;
    logic         zero;
    logic         neg;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] rs1 = '0;
  logic [W-1:0] rs2 = '0;
  logic [W-1:0] rd;
  logic         out_valid, zero, neg, borrow, ovf;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  alu_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .rs1(rs1), .rs2(rs2),
    .rd(rd), .out_valid(out_valid), .zero(zero), .neg(neg), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference: true signed/unsigned arithmetic on wide integers, then range checks.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, sd;
    longint max_s, min_s;
    max_s = (longint'(1) <<< (W - 1)) - 1;
    min_s = -(longint'(1) <<< (W - 1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sd = sa - sb;
    e.ovf    = (sd > max_s) || (sd < min_s);
    e.borrow = (longint'(a) < longint'(b));
    e.rd     = W'(sd);
`ifdef ALU_SUB_SAT_EN
    if (e.ovf) e.rd = (sa >= 0) ? W'(max_s) : W'(min_s);
`endif
    e.zero = (e.rd == '0);
    e.neg  = e.rd[W-1];
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    rs1 = a;
    rs2 = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    rs1 = W'($urandom);
    rs2 = W'($urandom);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n_txn++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got rd=%0h with out_valid=1, want no output", rd);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if ({rd, zero, neg, borrow, ovf} !== e) begin
            n_bad++;
            $display("FAIL txn%0d: got rd=%0h z=%0b n=%0b b=%0b v=%0b, want rd=%0h z=%0b n=%0b b=%0b v=%0b",
                     n_txn, rd, zero, neg, borrow, ovf, e.rd, e.zero, e.neg, e.borrow, e.ovf);
          end else begin
            $display("txn %0d rd=%0h z=%0b n=%0b b=%0b v=%0b ok", n_txn, rd, zero, neg, borrow, ovf);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] corners[8];
    logic [W-1:0] a, b;
    corners[0] = '0;
    corners[1] = W'(1);
    corners[2] = '1;
    corners[3] = {1'b1, {(W-1){1'b0}}};
    corners[4] = {1'b0, {(W-1){1'b1}}};
    corners[5] = W'(2);
    corners[6] = {1'b1, {(W-2){1'b0}}, 1'b1};
    corners[7] = {1'b0, {(W-2){1'b1}}, 1'b0};

    // Reset held across an edge with valid operands present.
    rs1 = W'(5);
    rs2 = W'(3);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_rd", 64'(rd), 64'(0));
    chk("reset_flags", 64'({out_valid, zero, neg, borrow, ovf}), 64'(0));
    rst_n = 1'b1;
    exp_q.push_back(model(W'(5), W'(3)));
    @(posedge clk);
    #1;
    chk("first_capture_rd", 64'(rd), 64'(2));

    issue(W'(1), W'(1));
    issue('1, '1);
    issue(W'(10), W'(-10));
    issue(W'(-10), W'(10));
    issue(W'(1140431715), W'(-1960705524 + 0) ^ W'(0));
    issue(W'(1140431715), W'(1960705524));
    issue(W'(2132968867), W'(-1113736153));
    issue(W'(0), {1'b1, {(W-1){1'b0}}});
    issue(W'(10), W'(-10));

    for (int i = 0; i < 3; i++) begin
      idle();
      chk("hold_rd", 64'(rd), 64'(20));
      chk("hold_out_valid", 64'(out_valid), 64'(0));
    end

    // Asynchronous reset pulse between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rd", 64'(rd), 64'(0));
    chk("async_reset_flags", 64'({out_valid, zero, neg, borrow, ovf}), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("post_reset_out_valid", 64'(out_valid), 64'(0));

    // Randomized traffic with corner operands mixed in and random bubbles.
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 4) == 0) idle();
      else issue(a, b);
    end

    idle();
    idle();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
